// File: rtl/stack_pointer_pkg.sv
// Shared calculator definitions for the stack pointer and the control-unit decoder.
package stack_pointer_pkg;

  localparam int unsigned SP_WIDTH = 16;
  localparam logic [SP_WIDTH-1:0] SP_RESET = 16'h01FF;

  typedef enum logic [1:0] {
    SP_HOLD = 2'b00,
    SP_INC  = 2'b01,
    SP_DEC  = 2'b10
  } sp_op_e;

  // Simultaneous inc and dec cancel out, so both map to hold.
  function automatic sp_op_e sp_decode(input logic inc, input logic dec);
    sp_op_e op;
    case ({inc, dec})
      2'b10:   op = SP_INC;
      2'b01:   op = SP_DEC;
      default: op = SP_HOLD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/stack_pointer.sv
// Top-of-stack address register; stack grows downward from the reset value.
module stack_pointer
  import stack_pointer_pkg::*;
#(
  parameter int unsigned          WIDTH       = SP_WIDTH,
  parameter logic [WIDTH-1:0]     RESET_VALUE = SP_RESET
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             INC,
  input  logic             DEC,
  output logic [WIDTH-1:0] OUT
);

  sp_op_e op;

  assign op = sp_decode(INC, DEC);

  // Wrap-around is intentional; bounds checking lives in the control unit.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      OUT <= RESET_VALUE;
    end else begin
      case (op)
        SP_INC:  OUT <= OUT + WIDTH'(1);
        SP_DEC:  OUT <= OUT - WIDTH'(1);
        default: OUT <= OUT;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_pointer.sv
// Directed checks of the stack pointer: reset, push/pop, cancel, wrap, async reset.
module tb_stack_pointer;

  logic        CLK;
  logic        RST;
  logic        INC;
  logic        DEC;
  logic [15:0] OUT;

  int total;
  int bad;

  stack_pointer dut (
    .CLK(CLK),
    .RST(RST),
    .INC(INC),
    .DEC(DEC),
    .OUT(OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [15:0] exp);
    total++;
    assert (OUT === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, OUT, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    RST = 1'b0;
    INC = 1'b0;
    DEC = 1'b0;

    // Reset is seen before the first clock edge at t=5.
    #2 RST = 1'b1;
    #1 chk("reset_async", 16'h01FF);
    repeat (4) @(negedge CLK);
    chk("reset_hold", 16'h01FF);

    RST = 1'b0;
    DEC = 1'b1;
    @(negedge CLK);
    DEC = 1'b0;
    chk("push", 16'h01FE);
    repeat (2) @(negedge CLK);
    chk("push_hold", 16'h01FE);

    INC = 1'b1;
    #1 chk("pop_before_edge", 16'h01FE);
    @(negedge CLK);
    INC = 1'b0;
    chk("pop", 16'h01FF);

    INC = 1'b1;
    DEC = 1'b1;
    @(negedge CLK);
    chk("both_1", 16'h01FF);
    repeat (2) @(negedge CLK);
    chk("both_3", 16'h01FF);
    INC = 1'b0;

    // DEC still high: 0x1FF more edges reaches zero, one more wraps.
    repeat (16'h01FF) @(negedge CLK);
    chk("dec_to_zero", 16'h0000);
    @(negedge CLK);
    chk("dec_wrap", 16'hFFFF);
    DEC = 1'b0;
    INC = 1'b1;
    @(negedge CLK);
    chk("inc_wrap", 16'h0000);
    @(negedge CLK);
    chk("inc_after_wrap", 16'h0001);
    INC = 1'b0;

    DEC = 1'b1;
    @(negedge CLK);
    chk("dec_before_rst", 16'h0000);
    #2 RST = 1'b1;
    #1 chk("rst_mid_async", 16'h01FF);
    @(negedge CLK);
    chk("rst_mid_hold", 16'h01FF);
    RST = 1'b0;
    #1 chk("rst_release_pre", 16'h01FF);
    @(negedge CLK);
    chk("rst_release_dec", 16'h01FE);
    DEC = 1'b0;
    @(negedge CLK);
    chk("final_hold", 16'h01FE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
